lcd_write_engine: RTL and testbench
===================================

# lcd_write_engine

Parametrised successor to the LCD power-on controller for the HD44780-compatible character LCD in 4-bit mode. It runs the complete power-on init sequence (15 ms wait, three 0x3 pulses, switch to 4-bit, four configuration bytes). It then exposes a one-byte command/data write port with a ready/valid-style handshake, splitting each byte into two nibble transfers with enforced execution delays. It sits between the text/cursor logic and the LCD pins (SF_D<11:8>, LCD_E, LCD_RS, LCD_RW, SF_CE0).

## Interface
- T_POWERON, 750000: cycles waited after reset before the first 0x3 pulse (15 ms at 50 MHz).
- T_INIT_A, 205000: wait after first 0x3 pulse (4.1 ms).
- T_INIT_B, 5000: wait after second 0x3 pulse (100 us).
- T_CMD, 2000: execution wait after third 0x3, the 0x2 pulse, and every byte (40 us).
- T_CLEAR, 82000: execution wait for long commands (1.64 ms); used only with the macro.
- E_PULSE, 12: LCD_E high time in cycles, ≥1.
- NIBBLE_GAP, 50: cycles between the two nibbles of a byte (1 us).
- ENTRY_MODE, 8'h06: third init byte.
- DISPLAY_CTRL, 8'h0C: fourth init byte.
- Clock  in  1  system clock (50 MHz nominal).
- Reset  in  1  asynchronous, active-low reset.
- iWrite  in  1  write request, sampled only while oReady=1.
- iRS  in  1  0=command, 1=data; captured with iWrite.
- iData  in  8  byte to send; captured with iWrite.
- oReady  out  1  engine idle and init complete; accepts iWrite.
- oInitDone  out  1  set once the init sequence finishes; sticky until reset.
- oLCD_Enabled  out  1  LCD_E.
- oLCD_RegisterSelect  out  1  LCD_RS.
- oLCD_ReadWrite  out  1  constant 0 (write-only).
- oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled).
- oLCD_Data  out  4  SF_D<11:8>.

## Operation
- Reset values: oReady=0, oInitDone=0, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, RW=0, SF=1, state=PWR_WAIT, counter=0.
- States: PWR_WAIT → PULSE3(×3 with waits T_INIT_A, T_INIT_B, T_CMD) → PULSE2 (wait T_CMD) → CFG (bytes 0x28, ENTRY_MODE, DISPLAY_CTRL, 0x01, RS=0) → IDLE → SEND_HI → GAP → SEND_LO → EXEC → IDLE.
- Init single-nibble pulses and CFG bytes use the same nibble-transfer and wait timing as user writes.
- oInitDone rises on entry to IDLE after the last CFG byte's wait. oReady=1 exactly when the state is IDLE.
- Handshake: iWrite=1 with oReady=1 at a rising edge captures iRS/iData. oReady=0 the next cycle. iWrite while oReady=0 is ignored; there is no queue.
- Nibble transfer: data and RS on the bus 1 setup cycle, then E high E_PULSE cycles, then 1 hold cycle with E=0 and data unchanged. High nibble goes first.
- oLCD_Data and RS hold their last value in IDLE and during waits.
- A single 32-bit down-counter serves all waits. It is reloaded on every state change, and a wait of N cycles ends when the counter reaches 0.
- Reset asserted mid-operation (any state) aborts immediately to the reset values, and the full init sequence reruns.

## Timing
- Write accepted at edge t: high nibble on bus t+1; E high t+2..t+E_PULSE+1; hold t+E_PULSE+2.
- GAP lasts NIBBLE_GAP cycles. The low nibble repeats the setup/E/hold pattern, then EXEC lasts T_CMD cycles.
- oReady returns at t + 2·(E_PULSE+2) + NIBBLE_GAP + T_CMD + 1. With defaults this is t+2079.
- The earliest back-to-back accept is at that same edge.
- oLCD_Enabled never glitches: registered output, zero-cycle high pulses impossible.

## Configuration
- LCD_LONG_CMD_EN defined: any RS=0 byte with value 0x01 or 0x02 or 0x03 (clear/home) uses T_CLEAR instead of T_CMD in EXEC. This also covers the CFG 0x01.
- LCD_LONG_CMD_EN undefined: every byte uses T_CMD. T_CLEAR is unused, and callers must pace clear/home themselves.

## Test plan
- Reset low 10 cycles then high, defaults → first E rise with data 0x3 at 750001±1 cycles; three 0x3 pulses, one 0x2, then nibbles 2,8,0,6,0,C,0,1; oInitDone=1, oReady=1 afterwards.
- After init, iWrite with iRS=1, iData=0x41 → E pulses with data 0x4 then 0x1, RS=1 on both, each E high 12 cycles; oReady back at t+2079.
- iWrite held high continuously for 3 bytes → exactly one byte accepted per oReady window; no extra E pulses.
- iWrite pulsed while oReady=0 (mid-GAP) → no capture; bus and later sequence unchanged.
- Reset low during EXEC of a user byte → outputs return to reset values asynchronously; full init replays.
- With LCD_LONG_CMD_EN, command 0x01 → EXEC 82000 cycles; command 0x80 → 2000 cycles; without the macro, both take 2000 cycles.

Source files
------------

// File: rtl/lcd_write_engine.sv
// HD44780 4-bit write engine: power-on init sequence, then a one-byte command/data write port.
// Optional LCD_LONG_CMD_EN: clear/home commands (0x01..0x03, RS=0) wait T_CLEAR instead of T_CMD.
module lcd_write_engine #(
    parameter int unsigned T_POWERON    = 750000,
    parameter int unsigned T_INIT_A     = 205000,
    parameter int unsigned T_INIT_B     = 5000,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter int unsigned E_PULSE      = 12,
    parameter int unsigned NIBBLE_GAP   = 50,
    parameter logic [7:0]  ENTRY_MODE   = 8'h06,
    parameter logic [7:0]  DISPLAY_CTRL = 8'h0C
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iWrite,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_SETUP,
        ST_E_HIGH,
        ST_HOLD,
        ST_GAP,
        ST_EXEC,
        ST_IDLE
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_cnt, w_cnt_next;
    logic        r_armed, w_armed_next;
    logic [2:0]  r_step, w_step_next;
    logic [7:0]  r_byte, w_byte_next;
    logic        r_rs, w_rs_next;
    logic        r_lo, w_lo_next;
    logic        r_single, w_single_next;
    logic        r_init_done, w_init_done_next;
    logic        r_e;
    logic [3:0]  r_data;
    logic        w_long_cmd;
    logic [31:0] w_exec_len;

    // Init table entry: {single-nibble flag, byte}; single-nibble items send only byte[3:0].
    function automatic logic [8:0] init_item(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: init_item = {1'b1, 8'h03};
            3'd3:             init_item = {1'b1, 8'h02};
            3'd4:             init_item = {1'b0, 8'h28};
            3'd5:             init_item = {1'b0, ENTRY_MODE};
            3'd6:             init_item = {1'b0, DISPLAY_CTRL};
            default:          init_item = {1'b0, 8'h01};
        endcase
    endfunction

`ifdef LCD_LONG_CMD_EN
    assign w_long_cmd = !r_single && !r_rs &&
                        (r_byte == 8'h01 || r_byte == 8'h02 || r_byte == 8'h03);
`else
    assign w_long_cmd = 1'b0;
`endif

    always_comb begin
        w_exec_len = w_long_cmd ? T_CLEAR : T_CMD;
        if (!r_init_done && r_step == 3'd0) begin
            w_exec_len = T_INIT_A;
        end else if (!r_init_done && r_step == 3'd1) begin
            w_exec_len = T_INIT_B;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = (r_cnt != 32'd0) ? r_cnt - 32'd1 : r_cnt;
        w_armed_next     = r_armed;
        w_step_next      = r_step;
        w_byte_next      = r_byte;
        w_rs_next        = r_rs;
        w_lo_next        = r_lo;
        w_single_next    = r_single;
        w_init_done_next = r_init_done;

        case (r_state)
            ST_PWR_WAIT: begin
                // Counter comes out of reset at 0, so the first cycle arms the power-on wait.
                if (!r_armed) begin
                    w_armed_next = 1'b1;
                    w_cnt_next   = T_POWERON - 32'd2;
                end else if (r_cnt == 32'd0) begin
                    w_state_next                 = ST_SETUP;
                    w_step_next                  = 3'd0;
                    {w_single_next, w_byte_next} = init_item(3'd0);
                    w_lo_next                    = w_single_next;
                    w_rs_next                    = 1'b0;
                end
            end
            ST_SETUP:  w_state_next = ST_E_HIGH;
            ST_E_HIGH: if (r_cnt == 32'd0) w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (!r_lo) begin
                    w_state_next = ST_GAP;
                    w_lo_next    = 1'b1;
                end else begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_GAP:    if (r_cnt == 32'd0) w_state_next = ST_SETUP;
            ST_EXEC: begin
                if (r_cnt == 32'd0) begin
                    if (r_init_done) begin
                        w_state_next = ST_IDLE;
                    end else if (r_step == 3'd7) begin
                        w_state_next     = ST_IDLE;
                        w_init_done_next = 1'b1;
                    end else begin
                        w_state_next                 = ST_SETUP;
                        w_step_next                  = r_step + 3'd1;
                        {w_single_next, w_byte_next} = init_item(r_step + 3'd1);
                        w_lo_next                    = w_single_next;
                        w_rs_next                    = 1'b0;
                    end
                end
            end
            ST_IDLE: begin
                if (iWrite) begin
                    w_state_next  = ST_SETUP;
                    w_byte_next   = iData;
                    w_rs_next     = iRS;
                    w_lo_next     = 1'b0;
                    w_single_next = 1'b0;
                end
            end
            default: w_state_next = ST_PWR_WAIT;
        endcase

        // Every state change reloads the shared counter with the new state's length minus one.
        if (w_state_next != r_state) begin
            case (w_state_next)
                ST_E_HIGH: w_cnt_next = E_PULSE - 32'd1;
                ST_GAP:    w_cnt_next = NIBBLE_GAP - 32'd1;
                ST_EXEC:   w_cnt_next = w_exec_len - 32'd1;
                default:   w_cnt_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_PWR_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt       <= 32'd0;
            r_armed     <= 1'b0;
            r_step      <= 3'd0;
            r_byte      <= 8'd0;
            r_rs        <= 1'b0;
            r_lo        <= 1'b0;
            r_single    <= 1'b0;
            r_init_done <= 1'b0;
            r_e         <= 1'b0;
            r_data      <= 4'd0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_armed     <= w_armed_next;
            r_step      <= w_step_next;
            r_byte      <= w_byte_next;
            r_rs        <= w_rs_next;
            r_lo        <= w_lo_next;
            r_single    <= w_single_next;
            r_init_done <= w_init_done_next;
            r_e         <= (w_state_next == ST_E_HIGH);
            // Bus changes only on SETUP entry, so it holds through the hold cycle, gaps and waits.
            if (w_state_next == ST_SETUP) begin
                r_data <= w_lo_next ? w_byte_next[3:0] : w_byte_next[7:4];
            end
        end
    end

    assign oReady                  = (r_state == ST_IDLE);
    assign oInitDone               = r_init_done;
    assign oLCD_Enabled            = r_e;
    assign oLCD_RegisterSelect     = r_rs;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_Data               = r_data;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Scoreboard bench for lcd_write_engine with shortened timing parameters.
`timescale 1ns/1ps
module tb_lcd_write_engine;

    localparam int T_POWERON  = 300;
    localparam int T_INIT_A   = 100;
    localparam int T_INIT_B   = 40;
    localparam int T_CMD      = 30;
    localparam int T_CLEAR    = 150;
    localparam int E_PULSE    = 3;
    localparam int NIBBLE_GAP = 5;
    localparam int XFER       = E_PULSE + 2;
    localparam int BYTE_BUSY  = 2 * XFER + NIBBLE_GAP;
`ifdef LCD_LONG_CMD_EN
    localparam int CLR_EXEC = T_CLEAR;
`else
    localparam int CLR_EXEC = T_CMD;
`endif
    // Reset release to IDLE: power-on, four single nibbles with their waits, four bytes.
    localparam int INIT_T = T_POWERON + 4 * XFER + T_INIT_A + T_INIT_B + 2 * T_CMD
                          + 4 * BYTE_BUSY + 3 * T_CMD + CLR_EXEC;

    logic       Clock  = 1'b0;
    logic       Reset  = 1'b0;
    logic       iWrite = 1'b0;
    logic       iRS    = 1'b0;
    logic [7:0] iData  = 8'd0;
    logic       oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect;
    logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] exp_q[$];
    int         rdy_q[$];

    lcd_write_engine #(
        .T_POWERON(T_POWERON), .T_INIT_A(T_INIT_A), .T_INIT_B(T_INIT_B),
        .T_CMD(T_CMD), .T_CLEAR(T_CLEAR), .E_PULSE(E_PULSE),
        .NIBBLE_GAP(NIBBLE_GAP), .ENTRY_MODE(8'h06), .DISPLAY_CTRL(8'h0C)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iWrite(iWrite), .iRS(iRS), .iData(iData),
        .oReady(oReady), .oInitDone(oInitDone), .oLCD_Enabled(oLCD_Enabled),
        .oLCD_RegisterSelect(oLCD_RegisterSelect), .oLCD_ReadWrite(oLCD_ReadWrite),
        .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endtask

    task automatic push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endtask

    // Monitor: pops the expected nibble on every E rise and the expected cycle on every oReady rise.
    logic prev_e = 1'b0, prev_rdy = 1'b0;
    int   rise_cyc = 0, rise_nib = 0;
    always @(negedge Clock) begin
        if (oLCD_Enabled && !prev_e) begin
            rise_cyc = cyc;
            rise_nib = {oLCD_RegisterSelect, oLCD_Data};
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got rs/nibble %0d, expected no pulse", rise_nib);
            end else begin
                chk("nibble", rise_nib, int'(exp_q.pop_front()));
            end
        end
        if (!oLCD_Enabled && prev_e && Reset) begin
            chk("e_width", cyc - rise_cyc, E_PULSE);
            chk("hold_data", {oLCD_RegisterSelect, oLCD_Data}, rise_nib);
        end
        if (oReady && !prev_rdy) begin
            if (rdy_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready at cycle %0d, expected none", cyc);
            end else begin
                chk("ready_time", cyc, rdy_q.pop_front());
            end
            chk("init_done_at_ready", oInitDone, 1);
        end
        prev_e   = oLCD_Enabled;
        prev_rdy = oReady;
    end

    task automatic wait_ready(input int maxc);
        int k;
        k = 0;
        while (!oReady && k < maxc) begin
            @(negedge Clock);
            k++;
        end
        if (!oReady) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready within %0d cycles, expected ready", maxc);
        end
    endtask

    // Leaves at the negedge right after the accepting posedge.
    task automatic do_write(input logic rs, input logic [7:0] b, input int exec);
        wait_ready(BYTE_BUSY + T_CLEAR + 20);
        iRS    = rs;
        iData  = b;
        iWrite = 1'b1;
        push_byte(rs, b);
        rdy_q.push_back(cyc + 1 + BYTE_BUSY + exec);
        @(negedge Clock);
        iWrite = 1'b0;
    endtask

    task automatic run_init();
        int rel, k;
        rel = cyc;
        push_init();
        rdy_q.push_back(rel + INIT_T);
        Reset = 1'b1;
        k = 0;
        while (!oLCD_Enabled && k < T_POWERON + 10) begin
            @(negedge Clock);
            k++;
        end
        n_tests++;
        if (!oLCD_Enabled || cyc < rel + T_POWERON || cyc > rel + T_POWERON + 2) begin
            n_fail++;
            $display("FAIL first_e_rise: got offset %0d, expected %0d +/-1", cyc - rel, T_POWERON + 1);
        end
        while (cyc < rel + INIT_T - 2) @(negedge Clock);
        chk("init_done_early", oInitDone, 0);
        chk("ready_early", oReady, 0);
        wait_ready(INIT_T);
        chk("init_done", oInitDone, 1);
    endtask

    logic [7:0] held_bytes [3] = '{8'h48, 8'h69, 8'h21};

    initial begin
        repeat (10) @(negedge Clock);
        chk("rst_ready", oReady, 0);
        chk("rst_init_done", oInitDone, 0);
        chk("rst_e", oLCD_Enabled, 0);
        chk("rst_rs", oLCD_RegisterSelect, 0);
        chk("rst_data", oLCD_Data, 0);
        chk("rst_rw", oLCD_ReadWrite, 0);
        chk("rst_sf", oLCD_StrataFlashControl, 1);

        run_init();

        // Data byte 'A'
        do_write(1'b1, 8'h41, T_CMD);

        // iWrite held high across three ready windows
        wait_ready(BYTE_BUSY + T_CLEAR + 20);
        iWrite = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready(BYTE_BUSY + T_CLEAR + 20);
            iRS   = 1'b1;
            iData = held_bytes[k];
            push_byte(1'b1, held_bytes[k]);
            rdy_q.push_back(cyc + 1 + BYTE_BUSY + T_CMD);
            @(negedge Clock);
        end
        iWrite = 1'b0;

        // Write request during GAP is ignored
        do_write(1'b0, 8'h37, T_CMD);
        repeat (6) @(negedge Clock);
        chk("busy_in_gap", oReady, 0);
        iRS    = 1'b1;
        iData  = 8'hFF;
        iWrite = 1'b1;
        @(negedge Clock);
        iWrite = 1'b0;

        // Clear command versus a plain command
        do_write(1'b0, 8'h01, CLR_EXEC);
        do_write(1'b0, 8'h80, T_CMD);

        // Reset during EXEC of a user byte
        do_write(1'b1, 8'h55, T_CMD);
        repeat (20) @(negedge Clock);
        #1 Reset = 1'b0;
        #1;
        chk("abort_ready", oReady, 0);
        chk("abort_init_done", oInitDone, 0);
        chk("abort_e", oLCD_Enabled, 0);
        chk("abort_rs", oLCD_RegisterSelect, 0);
        chk("abort_data", oLCD_Data, 0);
        chk("abort_sb_drained", exp_q.size(), 0);
        rdy_q.delete();
        repeat (5) @(negedge Clock);
        run_init();

        do_write(1'b1, 8'h7A, T_CMD);
        wait_ready(BYTE_BUSY + T_CLEAR + 20);
        repeat (5) @(negedge Clock);
        chk("nibbles_left", exp_q.size(), 0);
        chk("ready_events_left", rdy_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
